// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte path: byte width, the word
// assembler FSM encoding and default sizing parameters.
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_N              = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  // Word assembler states: gathering bytes, or holding a complete word.
  typedef enum logic {
    S_COLLECT = 1'b0,
    S_FULL    = 1'b1
  } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Byte-in / word-out bundle of the serial_to_parallel block.
// The slave modport is the assembler; the master modport is the
// environment (UART rx core on the byte side, consumer on the word side).
// With SERIAL_TO_PARALLEL_TIMEOUT_EN defined the bundle also carries the
// inter-byte timeout pulse.
interface serial_to_parallel_if
  import uart_pkg::*;
#(
  parameter int N = DEF_N
);

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;
  logic [N-1:0]      word;
  logic              word_valid;
  logic              word_ready;
  logic              overrun;
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
  logic              timeout;

  modport master (
    output rx_byte, rx_valid, word_ready,
    input  word, word_valid, overrun, timeout
  );

  modport slave (
    input  rx_byte, rx_valid, word_ready,
    output word, word_valid, overrun, timeout
  );
`else
  modport master (
    output rx_byte, rx_valid, word_ready,
    input  word, word_valid, overrun
  );

  modport slave (
    input  rx_byte, rx_valid, word_ready,
    output word, word_valid, overrun
  );
`endif

endinterface

// File: rtl/byte_slot_writer.sv
// Word register with byte-granular write: decodes a slot index into a
// per-byte write enable and stores one byte into that lane. Slots not
// addressed keep their previous contents. Shared with the transmit-side
// selector, which reads the same lane layout in reverse.
module byte_slot_writer
  import uart_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int BYTE_CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [BYTE_CNT_W-1:0] slot,
  input  logic [BYTE_W-1:0]     data,
  output logic [N-1:0]          word
);

  localparam int SLOTS = N / BYTE_W;

  // Byte-lane register: lane k is bits [8k+7:8k] and loads when addressed.
  // NOTE: sequential logic uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: this is a flop bank, not a RAM, so it takes the async reset and
  // powers up as a clean all-zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (slot == BYTE_CNT_W'(k)) begin
          word[k*BYTE_W +: BYTE_W] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Assembles a least-significant-byte-first stream from the UART receiver
// into one N-bit word and offers it downstream with valid/ready.
// A byte arriving while a finished word is still unclaimed is dropped and
// flagged by a one-cycle overrun pulse. All outputs come from flops.
// Optional: SERIAL_TO_PARALLEL_TIMEOUT_EN adds an inter-byte gap timer that
// abandons a stalled partial word and pulses 'timeout'.
module serial_to_parallel
  import uart_pkg::*;
#(
  parameter int N              = DEF_N,
  parameter int BYTE_CNT_W     = 3,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 iCE_CLK,
  input logic                 rst_n,
  serial_to_parallel_if.slave s2p
);

  localparam int                    SLOTS     = N / BYTE_W;
  localparam logic [BYTE_CNT_W-1:0] LAST_SLOT = BYTE_CNT_W'(SLOTS - 1);

  // Reject configurations the lane decoder or gap timer cannot represent.
  if ((N % BYTE_W) != 0 || N < 16) begin : g_bad_n
    $error("serial_to_parallel: N must be a multiple of 8 and at least 16");
  end
  if ((1 << BYTE_CNT_W) < SLOTS) begin : g_bad_cnt_w
    $error("serial_to_parallel: BYTE_CNT_W too narrow for N/8 slots");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("serial_to_parallel: TIMEOUT_CYCLES must be positive");
  end

  s2p_state_t            state_q, state_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  wr_en;
  logic [BYTE_CNT_W-1:0] wr_slot;
  logic [N-1:0]          word_q;

`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             timeout_q, timeout_d;
`endif

  byte_slot_writer #(
    .N          (N),
    .BYTE_CNT_W (BYTE_CNT_W)
  ) u_writer (
    .clk   (iCE_CLK),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .slot  (wr_slot),
    .data  (s2p.rx_byte),
    .word  (word_q)
  );

  // State, byte counter and pulse flags register.
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_COLLECT;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
      gap_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next state: byte capture, word completion, handshake and drop detection.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    wr_en     = 1'b0;
    wr_slot   = cnt_q;
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
    gap_d     = '0;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      S_COLLECT: begin
        if (s2p.rx_valid) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_SLOT) begin
            cnt_d   = '0;
            state_d = S_FULL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
        // A partial word that has gone quiet too long is abandoned.
        else if (cnt_q != '0) begin
          if (gap_q == GAP_W'(TIMEOUT_CYCLES)) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
`endif
      end
      S_FULL: begin
        if (s2p.word_ready) begin
          state_d = S_COLLECT;
          // A byte landing on the handshake cycle starts the next word.
          if (s2p.rx_valid) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            cnt_d   = BYTE_CNT_W'(1);
          end
        end else if (s2p.rx_valid) begin
          overrun_d = 1'b1;
        end
      end
    endcase
  end

  // Outputs decoded from registered state only; no input reaches an output.
  always_comb begin
    s2p.word       = word_q;
    s2p.word_valid = (state_q == S_FULL);
    s2p.overrun    = overrun_q;
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
    s2p.timeout    = timeout_q;
`endif
  end

endmodule
